clock_tick_sync: RTL and testbench

//  Receiving end of the divided clock: takes the slow ripple-divided clock (clock_div
//  div_clock output) back into the main clock domain without clocking logic from it.

---
 rtl/clock_tick_sync.sv | 185 ++++++++++++++++++
 tb/tb_clock_tick_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_sync.sv
// Brings a slow divided clock into the main clock domain as rise/fall enable ticks and tracks lock/loss.
// Optional period measurement enabled by defining CLOCK_TICK_PERIOD_EN.
module clock_tick_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned LOCK_EDGES  = 2,
   parameter int unsigned PERIOD_BITS = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   slow_clk_in,
   output logic                   rise_tick,
   output logic                   fall_tick,
   output logic                   locked,
   output logic                   lost,
   output logic [PERIOD_BITS-1:0] period,
   output logic                   period_valid
);

   localparam int unsigned GW = $clog2(TIMEOUT + 1);
   localparam int unsigned EW = $clog2(LOCK_EDGES + 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCKED = 2'd1,
      ST_LOST   = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   rise_tick_q, rise_tick_d;
   logic                   fall_tick_q, fall_tick_d;
   logic                   locked_q, locked_d;
   logic                   lost_q, lost_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
   state_e                 state_q, state_d;

   logic                   sync_c;
   logic                   rise_c;
   logic                   fall_c;
   logic                   timeout_c;

   // Edge detection, gap timing and the lock/loss state machine
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      sync_c      = sync_q[SYNC_STAGES-1];
      hist_d      = sync_c;
      rise_c      = sync_c & ~hist_q;
      fall_c      = ~sync_c & hist_q;
      rise_tick_d = rise_c;
      fall_tick_d = fall_c;
      locked_d    = (state_q == ST_LOCKED);
      lost_d      = (state_q == ST_LOST);
      state_d     = state_q;
      edge_cnt_d  = edge_cnt_q;

      if (rise_c) begin
         gap_d = '0;
      end else if (gap_q == GW'(TIMEOUT)) begin
         gap_d = gap_q;
      end else begin
         gap_d = gap_q + GW'(1);
      end
      timeout_c = (gap_q == GW'(TIMEOUT - 1)) & ~rise_c;

      unique case (state_q)
         ST_SEARCH: begin
            if (rise_c) begin
               if (edge_cnt_q == EW'(LOCK_EDGES - 1)) begin
                  state_d    = ST_LOCKED;
                  edge_cnt_d = '0;
               end else begin
                  edge_cnt_d = edge_cnt_q + EW'(1);
               end
            end else if (timeout_c) begin
               edge_cnt_d = '0;
            end
         end
         ST_LOCKED: begin
            if (timeout_c) begin
               state_d = ST_LOST;
            end
         end
         ST_LOST: begin
            // The edge that leaves LOST already counts toward the next lock
            if (rise_c) begin
               if (LOCK_EDGES <= 1) begin
                  state_d    = ST_LOCKED;
                  edge_cnt_d = '0;
               end else begin
                  state_d    = ST_SEARCH;
                  edge_cnt_d = EW'(1);
               end
            end
         end
         default: begin
            state_d    = ST_SEARCH;
            edge_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q      <= '0;
         hist_q      <= 1'b0;
         rise_tick_q <= 1'b0;
         fall_tick_q <= 1'b0;
         locked_q    <= 1'b0;
         lost_q      <= 1'b0;
         gap_q       <= '0;
         edge_cnt_q  <= '0;
         state_q     <= ST_SEARCH;
      end else begin
         sync_q      <= sync_d;
         hist_q      <= hist_d;
         rise_tick_q <= rise_tick_d;
         fall_tick_q <= fall_tick_d;
         locked_q    <= locked_d;
         lost_q      <= lost_d;
         gap_q       <= gap_d;
         edge_cnt_q  <= edge_cnt_d;
         state_q     <= state_d;
      end
   end

   assign rise_tick = rise_tick_q;
   assign fall_tick = fall_tick_q;
   assign locked    = locked_q;
   assign lost      = lost_q;

`ifdef CLOCK_TICK_PERIOD_EN
   logic [PERIOD_BITS-1:0] period_cnt_q, period_cnt_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic                   period_valid_q, period_valid_d;
   logic                   have_prev_q, have_prev_d;

   // Period measurement between consecutive rises; no previous edge after reset or loss
   always_comb begin
      period_cnt_d   = period_cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      have_prev_d    = have_prev_q;

      if (rise_c) begin
         period_cnt_d = '0;
      end else if (period_cnt_q != '1) begin
         period_cnt_d = period_cnt_q + PERIOD_BITS'(1);
      end

      if (rise_c) begin
         have_prev_d = 1'b1;
         if (have_prev_q) begin
            period_valid_d = 1'b1;
            period_d       = (period_cnt_q == '1) ? period_cnt_q
                                                  : period_cnt_q + PERIOD_BITS'(1);
         end
      end else if ((state_q == ST_LOCKED) && timeout_c) begin
         have_prev_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         period_cnt_q   <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         have_prev_q    <= 1'b0;
      end else begin
         period_cnt_q   <= period_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         have_prev_q    <= have_prev_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clock_tick_sync.sv
// Randomised scoreboard bench for clock_tick_sync; reference model works on edge times, not counters.
// Period checks follow CLOCK_TICK_PERIOD_EN when defined.
module tb_clock_tick_sync;

   localparam int S    = 2;
   localparam int T    = 64;
   localparam int LE   = 2;
   localparam int PB   = 16;
   localparam int MAXC = 40000;
   localparam int PMAX = 65535;

   logic          clock;
   logic          reset;
   logic          slow_clk_in;
   logic          rise_tick;
   logic          fall_tick;
   logic          locked;
   logic          lost;
   logic [PB-1:0] period;
   logic          period_valid;

   clock_tick_sync #(
      .SYNC_STAGES(S),
      .TIMEOUT    (T),
      .LOCK_EDGES (LE),
      .PERIOD_BITS(PB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .slow_clk_in (slow_clk_in),
      .rise_tick   (rise_tick),
      .fall_tick   (fall_tick),
      .locked      (locked),
      .lost        (lost),
      .period      (period),
      .period_valid(period_valid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model state: times are edge indices, state 0=search 1=locked 2=lost
   int   n;
   bit   xh [MAXC];
   int   rst_edge;
   int   st;
   int   ecnt;
   int   anchor;
   int   last_rise;
   bit   fired;
   bit   have_prev;
   int   per;
   bit   level;

   logic [20:0] exp_q[$];
   int          tests;
   int          fails;

   function automatic bit xv(input int k);
      if (k < 0 || k <= rst_edge) return 1'b0;
      return xh[k];
   endfunction

   // Apply one cycle of stimulus, then predict the outputs after the sampling edge
   task automatic step(input bit v, input bit r);
      bit          rs, fl, lk, ls, pv;
      logic [20:0] e;
      slow_clk_in = v;
      reset       = r;
      @(posedge clock);
      n     = n + 1;
      xh[n] = v;
      if (r) begin
         rst_edge  = n;
         st        = 0;
         ecnt      = 0;
         anchor    = n;
         fired     = 1'b0;
         have_prev = 1'b0;
         per       = 0;
         e         = '0;
      end else begin
         rs = xv(n - S) & ~xv(n - S - 1);
         fl = ~xv(n - S) & xv(n - S - 1);
         lk = (st == 1);
         ls = (st == 2);
         pv = 1'b0;
         if (rs) begin
            if (have_prev) begin
               per = ((n - last_rise) > PMAX) ? PMAX : (n - last_rise);
               pv  = 1'b1;
            end
            have_prev = 1'b1;
            last_rise = n;
            anchor    = n;
            fired     = 1'b0;
            if (st == 0) begin
               ecnt = ecnt + 1;
               if (ecnt >= LE) begin
                  st   = 1;
                  ecnt = 0;
               end
            end else if (st == 2) begin
               st   = (LE <= 1) ? 1 : 0;
               ecnt = (LE <= 1) ? 0 : 1;
            end
         end else if (!fired && (n - anchor) == T) begin
            fired = 1'b1;
            if (st == 0) begin
               ecnt = 0;
            end else if (st == 1) begin
               st        = 2;
               have_prev = 1'b0;
            end
         end
`ifdef CLOCK_TICK_PERIOD_EN
         e = {rs, fl, lk, ls, pv, PB'(per)};
`else
         e = {rs, fl, lk, ls, 1'b0, 16'd0};
`endif
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic hold(input bit v, input int cycles);
      for (int i = 0; i < cycles; i++) step(v, 1'b0);
      level = v;
   endtask

   task automatic wave(input int hi, input int lo, input int count);
      for (int c = 0; c < count; c++) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set; pop and compare
   initial begin
      logic [20:0] e;
      logic [20:0] a;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {rise_tick, fall_tick, locked, lost, period_valid, period};
            tests = tests + 1;
            if (a !== e) begin
               fails = fails + 1;
               $display("FAIL outputs edge=%0d rise/fall/lock/lost/pv actual=%b%b%b%b%b period=%0d required=%b%b%b%b%b period=%0d",
                        n, a[20], a[19], a[18], a[17], a[16], a[15:0],
                        e[20], e[19], e[18], e[17], e[16], e[15:0]);
            end
            tests = tests + 1;
            if ((rise_tick & fall_tick) !== 1'b0) begin
               fails = fails + 1;
               $display("FAIL both_ticks edge=%0d actual=%b required=0", n, rise_tick & fall_tick);
            end
         end
      end
   end

   initial begin
      int mode, hi, lo, cnt, tot;
      tests       = 0;
      fails       = 0;
      n           = 0;
      rst_edge    = 0;
      level       = 1'b0;
      reset       = 1'b1;
      slow_clk_in = 1'b0;
      last_rise   = 0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      wave(8, 8, 6);          // period 16: ticks, lock, period 16
      wave(20, 20, 4);        // period 40
      hold(1'b0, 100);        // stall -> lost
      wave(8, 8, 4);          // relock from lost
      wave(32, 32, 4);        // rise exactly at the timeout boundary
      wave(33, 32, 3);        // one cycle past the boundary
      wave(8, 8, 3);
      hold(1'b1, 3);
      step(1'b1, 1'b1);       // reset while locked
      hold(1'b1, 5);
      hold(1'b0, 8);
      wave(8, 8, 4);

      for (int it = 0; it < 40; it++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: begin
               hi  = int'($urandom_range(2, 40));
               lo  = int'($urandom_range(2, 40));
               cnt = int'($urandom_range(1, 5));
               wave(hi, lo, cnt);
            end
            1: hold(1'($urandom_range(0, 1)), int'($urandom_range(50, 150)));
            2: begin
               step(level, 1'b1);
               hold(level, int'($urandom_range(1, 6)));
            end
            default: begin
               tot = 63 + int'($urandom_range(0, 2));
               hi  = int'($urandom_range(4, 30));
               wave(hi, tot - hi, int'($urandom_range(2, 4)));
            end
         endcase
      end

      hold(level, 2);
      @(negedge clock);
      #1;
      tests = tests + 1;
      if (exp_q.size() != 0) begin
         fails = fails + 1;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
